branch_cmp_seq: RTL and testbench

- Multi-cycle branch-compare sequencer for the NovaEdge32 execute stage.
- Time-shares a single 16-bit magnitude comparator (comparatorX16) across the upper and lower halves of two 32-bit operands.
- Early-out when the upper halves differ; otherwise compares the lower halves unsigned.
- Decodes funct3 into a branch-taken decision, with valid/ready handshakes on both sides and a pipeline flush.

---
 rtl/nova_pkg.sv | 44 ++++
 rtl/comparatorX16.sv | 19 +
 rtl/branch_cmp_seq.sv | 142 ++++++++++++++
 tb/tb_branch_cmp_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/nova_pkg.sv
// Shared NovaEdge32 branch-compare definitions: widths, funct3 codes,
// sequencer states and the taken/illegal decode.
package nova_pkg;

    localparam int XLEN = 32;
    localparam int HALF = XLEN / 2;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DONE = 2'd3
    } br_state_t;

    typedef struct packed {
        logic taken;
        logic illegal;
    } br_decision_t;

    // 010/011 are not branch encodings; they report illegal and never take.
    function automatic br_decision_t decode_branch(input logic [2:0] f3,
                                                   input logic       eq,
                                                   input logic       lt);
        br_decision_t d;
        d.taken   = 1'b0;
        d.illegal = 1'b0;
        case (f3)
            BR_BEQ:           d.taken = eq;
            BR_BNE:           d.taken = ~eq;
            BR_BLT, BR_BLTU:  d.taken = lt;
            BR_BGE, BR_BGEU:  d.taken = ~lt;
            default:          d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/comparatorX16.sv
// 16-bit magnitude comparator with selectable two's-complement interpretation.
module comparatorX16
    import nova_pkg::*;
(
    input  logic [HALF-1:0] x,
    input  logic [HALF-1:0] y,
    input  logic            sign,
    output logic            eq,
    output logic            gt,
    output logic            lt
);

    always_comb begin
        eq = (x == y);
        lt = sign ? ($signed(x) < $signed(y)) : (x < y);
        gt = ~eq & ~lt;
    end

endmodule

// File: rtl/branch_cmp_seq.sv
// Multi-cycle branch compare: upper halves first (signedness per funct3),
// lower halves unsigned only when the upper halves tie.
module branch_cmp_seq
    import nova_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic            equal,
    output logic            greater,
    output logic            less,
    output logic            illegal
);

    br_state_t       state_q, state_d;
    logic [XLEN-1:0] op1_q, op1_d;
    logic [XLEN-1:0] op2_q, op2_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            signed_q, signed_d;
    logic            equal_q, equal_d;
    logic            greater_q, greater_d;
    logic            less_q, less_d;
    logic            taken_q, taken_d;
    logic            illegal_q, illegal_d;

    logic [HALF-1:0] cmp_x, cmp_y;
    logic            cmp_sign, cmp_eq, cmp_gt, cmp_lt;
    br_decision_t    dec;

    comparatorX16 u_cmp (
        .x    (cmp_x),
        .y    (cmp_y),
        .sign (cmp_sign),
        .eq   (cmp_eq),
        .gt   (cmp_gt),
        .lt   (cmp_lt)
    );

    assign in_ready  = (state_q == IDLE) && !flush;
    assign out_valid = (state_q == DONE);
    assign taken     = taken_q;
    assign equal     = equal_q;
    assign greater   = greater_q;
    assign less      = less_q;
    assign illegal   = illegal_q;

    // The lower half carries no sign, so sign is only ever applied in HI.
    always_comb begin
        cmp_x    = (state_q == HI) ? op1_q[XLEN-1:HALF] : op1_q[HALF-1:0];
        cmp_y    = (state_q == HI) ? op2_q[XLEN-1:HALF] : op2_q[HALF-1:0];
        cmp_sign = (state_q == HI) && signed_q;
    end

    always_comb begin
        state_d   = state_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        funct3_d  = funct3_q;
        signed_d  = signed_q;
        equal_d   = equal_q;
        greater_d = greater_q;
        less_d    = less_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        dec       = decode_branch(funct3_q, cmp_eq, cmp_lt);

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op1_d    = rs1;
                        op2_d    = rs2;
                        funct3_d = funct3;
                        signed_d = ~funct3[1];
                        state_d  = HI;
                    end
                end
                HI: begin
                    if (!cmp_eq) begin
                        equal_d   = 1'b0;
                        greater_d = cmp_gt;
                        less_d    = cmp_lt;
                        taken_d   = dec.taken;
                        illegal_d = dec.illegal;
                        state_d   = DONE;
                    end else begin
                        state_d = LO;
                    end
                end
                LO: begin
                    equal_d   = cmp_eq;
                    greater_d = cmp_gt;
                    less_d    = cmp_lt;
                    taken_d   = dec.taken;
                    illegal_d = dec.illegal;
                    state_d   = DONE;
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op1_q     <= '0;
            op2_q     <= '0;
            funct3_q  <= '0;
            signed_q  <= 1'b0;
            equal_q   <= 1'b0;
            greater_q <= 1'b0;
            less_q    <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            funct3_q  <= funct3_d;
            signed_q  <= signed_d;
            equal_q   <= equal_d;
            greater_q <= greater_d;
            less_q    <= less_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_branch_cmp_seq.sv
// Scoreboard bench for branch_cmp_seq: directed vectors push expectations,
// an independent monitor pops and compares whenever out_valid is seen.
module tb_branch_cmp_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        taken, equal, greater, less, illegal;

    typedef struct {
        logic eq;
        logic gt;
        logic lt;
        logic tk;
        logic il;
        int   lat;
        int   acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   pending = 0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    branch_cmp_seq dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .taken     (taken),
        .equal     (equal),
        .greater   (greater),
        .less      (less),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    // Monitor: first sighting of out_valid pops one expectation; the flags are
    // then compared on every cycle they are held, covering stability under stall.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (!pending) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_out_valid", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    pending = 1;
                    checkOutput("latency", cyc - cur.acc, cur.lat);
                end
            end
            if (pending) begin
                checkOutput("equal", int'(equal), int'(cur.eq));
                checkOutput("greater", int'(greater), int'(cur.gt));
                checkOutput("less", int'(less), int'(cur.lt));
                checkOutput("taken", int'(taken), int'(cur.tk));
                checkOutput("illegal", int'(illegal), int'(cur.il));
                checkOutput("in_ready_while_done", int'(in_ready), 0);
                if (out_ready) pending = 0;
            end
        end
    end

    task automatic issueRequest(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
        rs1 = a;
        rs2 = b;
        funct3 = f;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                                 input logic eq, input logic gt, input logic lt,
                                 input logic tk, input logic il, input int lat);
        exp_t e;
        issueRequest(a, b, f);
        e.eq = eq; e.gt = gt; e.lt = lt; e.tk = tk; e.il = il;
        e.lat = lat;
        e.acc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((exp_q.size() != 0 || pending) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || pending) checkOutput("drain_timeout", 0, 1);
    endtask

    initial begin
        int n;
        #12;
        @(negedge clk);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_in_ready", int'(in_ready), 0 + 1);
        checkOutput("reset_flags", int'({taken, equal, greater, less, illegal}), 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", int'(in_ready), 1);

        // Early-out and full-path vectors (flags: eq gt lt taken illegal, latency)
        applyStimulus(32'h0001_0000, 32'h0000_FFFF, 3'b110, 0, 1, 0, 0, 0, 1);
        applyStimulus(32'hFFFF_0001, 32'hFFFF_0002, 3'b100, 0, 0, 1, 1, 0, 2);
        applyStimulus(32'hFFFF_0001, 32'hFFFF_0002, 3'b101, 0, 0, 1, 0, 0, 2);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 3'b100, 0, 0, 1, 1, 0, 1);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 3'b110, 0, 1, 0, 0, 0, 1);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 3'b111, 0, 1, 0, 1, 0, 1);
        applyStimulus(32'h0000_0005, 32'h0000_0005, 3'b000, 1, 0, 0, 1, 0, 2);
        applyStimulus(32'h0000_0005, 32'h0000_0005, 3'b010, 1, 0, 0, 0, 1, 2);
        applyStimulus(32'h0000_8000, 32'h0000_0001, 3'b100, 0, 1, 0, 0, 0, 2);
        waitIdle();

        // Backpressure: hold out_ready low for 5 cycles after the result appears
        out_ready = 1'b0;
        applyStimulus(32'h1234_5678, 32'h1234_5678, 3'b001, 1, 0, 0, 0, 0, 2);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_out_valid_seen", int'(out_valid), 1);
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_out_valid_held", int'(out_valid), 1);
            checkOutput("bp_in_ready_low", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_in_ready_after", int'(in_ready), 1);
        checkOutput("bp_out_valid_after", int'(out_valid), 0);
        waitIdle();

        // Flush while in HI; a request offered in the flush cycle is refused
        issueRequest(32'h0000_0007, 32'h0000_0007, 3'b000);
        flush = 1'b1;
        rs1 = 32'h0000_0009;
        rs2 = 32'h0000_0009;
        funct3 = 3'b000;
        in_valid = 1'b1;
        @(negedge clk);
        checkOutput("flush_in_ready_low", int'(in_ready), 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_out_valid", int'(out_valid), 0);
        checkOutput("flush_in_ready", int'(in_ready), 1);
        repeat (4) @(negedge clk);
        checkOutput("flush_still_idle", int'(in_ready), 1);

        // Asynchronous reset while in LO; flags from the prior result must clear
        applyStimulus(32'h0000_0003, 32'h0000_0003, 3'b000, 1, 0, 0, 1, 0, 2);
        waitIdle();
        issueRequest(32'h1111_2222, 32'h1111_2222, 3'b000);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_in_ready", int'(in_ready), 1);
        checkOutput("rst_equal_cleared", int'(equal), 0);
        checkOutput("rst_taken_cleared", int'(taken), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_no_pulse", int'(out_valid), 0);

        // Recovery after reset
        applyStimulus(32'h0000_0001, 32'h0001_0000, 3'b111, 0, 0, 1, 0, 0, 1);
        waitIdle();
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "[TB] timeout");
    end

endmodule
